trace_tpiu_matcher: RTL and testbench
=====================================

Name: trace_tpiu_matcher

Overview:
- Downstream consumer of the trace register block: deserialises TPIU TRACEDATA (1/2/4 lanes), finds frame sync, assembles bytes and compares a byte-history buffer against 8 masked patterns.
- Produces the trigger plus all status values the register block reads back: matching vector, buffers, sync flag, per-rule counts.
- Single trace_clk domain; register-side inputs are quasi-static and are changed only while idle or followed by a resync.

Parameters:
- pBUFFER_SIZE, 64, width in bits of raw window, match buffer and patterns/masks; multiple of 8, ≥32.
- pMATCH_RULES, 8, number of pattern/mask/count rules; fixed at 8.

Ports:
- trace_clk  in  1  trace clock; TRACEDATA sampled on rising edge.
- reset_i  in  1  asynchronous active-high reset.
- trace_data  in  4  TRACEDATA lanes; lane 0 carries the earliest bit of each sample.
- I_trace_width  in  3  lanes in use: 1, 2 or 4; any other value is treated as 4.
- I_trace_reset_sync  in  1  level; while high, forces unsynchronised state and clears counts.
- I_pattern_enable  in  8  per-rule enable.
- I_trig_toggle  in  1  0 = pulse trigger, 1 = toggle trigger.
- I_trace_pattern0..7  in  pBUFFER_SIZE each  match values.
- I_trace_mask0..7  in  pBUFFER_SIZE each  compare masks; 1 = bit compared.
- O_synchronized  out  1  frame sync held.
- O_matching_buffer  out  pBUFFER_SIZE  byte history; newest byte in [7:0].
- O_last_blurb  out  pBUFFER_SIZE  raw window captured at the most recent sync detect.
- O_matching_pattern  out  8  rule hits from the most recent evaluation.
- O_trace_count0..7  out  8 each  saturating per-rule hit counts.
- O_trig  out  1  trigger output.

Behaviour:
- Reset: every output is 0, all internal state is 0, state is UNSYNC.
- Lane count w = 1, 2 or 4, taken from I_trace_width every cycle.
- Raw window: raw_next = {trace_data[w-1:0], raw[B-1:w]}; bits arrive LSB-first and the oldest bit sits at the LSB. The window updates every cycle in both states.
- Sync detect: raw_next[B-1:B-32] == 32'h7FFF_FFFF. On that same edge:
  - O_synchronized <= 1; state -> SYNC.
  - bit counter <= 0 and partial byte is discarded.
  - O_matching_buffer <= 0.
  - O_last_blurb <= raw_next.
  - The next sample is the first data bit.
- Sync detect while already in SYNC realigns with the same actions and is not an error.
- In SYNC:
  - byte_next = {trace_data[w-1:0], byte_sr[7:w]}.
  - bitcnt advances by w each cycle.
  - When bitcnt + w == 8, the byte completes: O_matching_buffer <= {O_matching_buffer[B-9:0], byte_next}, bitcnt <= 0, eval_pending <= 1.
  - On a cycle where sync detect and byte completion coincide, sync detect wins and no byte is pushed.
- Evaluation happens on the edge after a byte push (latency 1):
  - hit[i] = I_pattern_enable[i] & (mask_i != 0) & (((buffer ^ pattern_i) & mask_i) == 0).
  - O_matching_pattern <= hit; the value holds until the next evaluation.
  - O_trace_count_i increments on hit[i] and saturates at 255.
- Trigger, on the same edge as evaluation, when any hit:
  - I_trig_toggle = 0: O_trig high for exactly 1 cycle.
  - I_trig_toggle = 1: O_trig inverts and holds level.
  - With no hit, pulse mode drives O_trig to 0.
- I_trace_reset_sync high, with priority over everything except reset_i:
  - State -> UNSYNC; O_synchronized, bitcnt, byte_sr, O_matching_buffer, O_matching_pattern, eval_pending and counts all go to 0.
  - The raw window keeps shifting, so sync detection is possible the cycle after deassertion.
  - O_last_blurb and O_trig are retained.
- In UNSYNC: no byte pushes and no evaluations occur.
- Changing I_trace_width while in SYNC gives undefined alignment; firmware pulses I_trace_reset_sync after any width change.
- reset_i asserted mid-byte or mid-evaluation clears immediately, asynchronously.

Test Plan:
1. Width 4, nibbles F,F,F,F,F,F,F,7 -> O_synchronized = 1 on the 8th sample edge; O_last_blurb[63:32] = 32'h7FFF_FFFF; O_matching_buffer = 0.
2. After sync, nibbles 5,A; pattern0 = 0xA5, mask0 = 0xFF, enable = 0x01, toggle = 0 -> O_matching_buffer[7:0] = 0xA5 after the 2nd sample; one cycle later O_matching_pattern = 0x01, O_trace_count0 = 1, O_trig high for one cycle.
3. Same as 2 with toggle = 1, byte 0xA5 sent 3 times -> O_trig toggles 0→1→0→1; count0 = 3.
4. Width 1, sync sent as 31 ones then one zero, then byte 0x3C sent LSB-first over 8 cycles -> buffer[7:0] = 0x3C after the 8th bit; rule with mask 0 never hits even when enabled.
5. Byte 0xA5 sent 300 times with rule 0 matching -> O_trace_count0 saturates at 255 and holds.
6. Assert I_trace_reset_sync mid-byte -> O_synchronized, buffer and counts = 0 next edge; no byte is pushed until a new 0x7FFFFFFF is received.

Source files
------------

// File: rtl/trace_tpiu_matcher.sv
// trace_tpiu_matcher: TPIU trace deserialiser with frame sync, byte history and masked pattern trigger
module trace_tpiu_matcher #(
  parameter int pBUFFER_SIZE = 64,
  parameter int pMATCH_RULES = 8
) (
  input  logic                    trace_clk,
  input  logic                    reset_i,
  input  logic [3:0]              trace_data,
  input  logic [2:0]              I_trace_width,
  input  logic                    I_trace_reset_sync,
  input  logic [7:0]              I_pattern_enable,
  input  logic                    I_trig_toggle,
  input  logic [pBUFFER_SIZE-1:0] I_trace_pattern0,
  input  logic [pBUFFER_SIZE-1:0] I_trace_pattern1,
  input  logic [pBUFFER_SIZE-1:0] I_trace_pattern2,
  input  logic [pBUFFER_SIZE-1:0] I_trace_pattern3,
  input  logic [pBUFFER_SIZE-1:0] I_trace_pattern4,
  input  logic [pBUFFER_SIZE-1:0] I_trace_pattern5,
  input  logic [pBUFFER_SIZE-1:0] I_trace_pattern6,
  input  logic [pBUFFER_SIZE-1:0] I_trace_pattern7,
  input  logic [pBUFFER_SIZE-1:0] I_trace_mask0,
  input  logic [pBUFFER_SIZE-1:0] I_trace_mask1,
  input  logic [pBUFFER_SIZE-1:0] I_trace_mask2,
  input  logic [pBUFFER_SIZE-1:0] I_trace_mask3,
  input  logic [pBUFFER_SIZE-1:0] I_trace_mask4,
  input  logic [pBUFFER_SIZE-1:0] I_trace_mask5,
  input  logic [pBUFFER_SIZE-1:0] I_trace_mask6,
  input  logic [pBUFFER_SIZE-1:0] I_trace_mask7,
  output logic                    O_synchronized,
  output logic [pBUFFER_SIZE-1:0] O_matching_buffer,
  output logic [pBUFFER_SIZE-1:0] O_last_blurb,
  output logic [7:0]              O_matching_pattern,
  output logic [7:0]              O_trace_count0,
  output logic [7:0]              O_trace_count1,
  output logic [7:0]              O_trace_count2,
  output logic [7:0]              O_trace_count3,
  output logic [7:0]              O_trace_count4,
  output logic [7:0]              O_trace_count5,
  output logic [7:0]              O_trace_count6,
  output logic [7:0]              O_trace_count7,
  output logic                    O_trig
);
  localparam int B = pBUFFER_SIZE;
  typedef enum logic {UNSYNC, SYNC} state_t;
  state_t state, state_next;
  logic [B-1:0] raw, raw_next;
  logic [B-1:0] pat [pMATCH_RULES];
  logic [B-1:0] msk [pMATCH_RULES];
  logic [7:0] cnt [pMATCH_RULES];
  logic [7:0] byte_sr, byte_next;
  logic [pMATCH_RULES-1:0] hit;
  logic [3:0] lanes, bit_sum;
  logic [2:0] bitcnt;
  logic sync_det, push, eval, eval_pending;
  assign pat = '{I_trace_pattern0, I_trace_pattern1, I_trace_pattern2, I_trace_pattern3,
                 I_trace_pattern4, I_trace_pattern5, I_trace_pattern6, I_trace_pattern7};
  assign msk = '{I_trace_mask0, I_trace_mask1, I_trace_mask2, I_trace_mask3,
                 I_trace_mask4, I_trace_mask5, I_trace_mask6, I_trace_mask7};
  assign {O_trace_count0, O_trace_count1, O_trace_count2, O_trace_count3} = {cnt[0], cnt[1], cnt[2], cnt[3]};
  assign {O_trace_count4, O_trace_count5, O_trace_count6, O_trace_count7} = {cnt[4], cnt[5], cnt[6], cnt[7]};
  // lane decode and LSB-first shift of the raw window and partial byte; lane 0 is the oldest bit
  always_comb begin
    lanes = (I_trace_width == 3'd1) ? 4'd1 : (I_trace_width == 3'd2) ? 4'd2 : 4'd4;
    raw_next = (lanes == 4'd1) ? {trace_data[0], raw[B-1:1]} :
               (lanes == 4'd2) ? {trace_data[1:0], raw[B-1:2]} : {trace_data, raw[B-1:4]};
    byte_next = (lanes == 4'd1) ? {trace_data[0], byte_sr[7:1]} :
                (lanes == 4'd2) ? {trace_data[1:0], byte_sr[7:2]} : {trace_data, byte_sr[7:4]};
    bit_sum = {1'b0, bitcnt} + lanes;
    sync_det = raw_next[B-1 -: 32] == 32'h7FFF_FFFF;
  end
  // sync state register
  always_ff @(posedge trace_clk or posedge reset_i)
    if (reset_i) state <= UNSYNC;
    else state <= state_next;
  // resync request beats a sync pattern; a sync pattern (re)enters SYNC from either state
  always_comb state_next = I_trace_reset_sync ? UNSYNC : sync_det ? SYNC : state;
  // byte push only in SYNC when the byte completes and no realign happens on the same edge
  always_comb begin
    push = !I_trace_reset_sync && !sync_det && state == SYNC && bit_sum == 4'd8;
    eval = !I_trace_reset_sync && eval_pending;
  end
  // per-rule masked compare; an all-zero mask never matches
  always_comb begin
    hit = '0;
    for (int i = 0; i < pMATCH_RULES; i++)
      hit[i] = I_pattern_enable[i] && |msk[i] && ((O_matching_buffer ^ pat[i]) & msk[i]) == '0;
  end
  // raw window shifts every cycle regardless of state
  always_ff @(posedge trace_clk or posedge reset_i)
    if (reset_i) raw <= '0;
    else raw <= raw_next;
  // byte alignment, history buffer and sync capture
  always_ff @(posedge trace_clk or posedge reset_i)
    if (reset_i) begin
      O_synchronized <= 1'b0;
      O_matching_buffer <= '0;
      O_last_blurb <= '0;
      byte_sr <= '0;
      bitcnt <= '0;
      eval_pending <= 1'b0;
    end else if (I_trace_reset_sync) begin
      O_synchronized <= 1'b0;
      O_matching_buffer <= '0;
      byte_sr <= '0;
      bitcnt <= '0;
      eval_pending <= 1'b0;
    end else begin
      eval_pending <= push;
      if (sync_det) begin
        O_synchronized <= 1'b1;
        O_matching_buffer <= '0;
        O_last_blurb <= raw_next;
        byte_sr <= '0;
        bitcnt <= '0;
      end else if (state == SYNC) begin
        byte_sr <= byte_next;
        bitcnt <= push ? 3'd0 : bit_sum[2:0];
        if (push) O_matching_buffer <= {O_matching_buffer[B-9:0], byte_next};
      end
    end
  // evaluation results, saturating counts and trigger; resync leaves the trigger level alone
  always_ff @(posedge trace_clk or posedge reset_i)
    if (reset_i) begin
      O_matching_pattern <= '0;
      O_trig <= 1'b0;
      for (int i = 0; i < pMATCH_RULES; i++) cnt[i] <= '0;
    end else if (I_trace_reset_sync) begin
      O_matching_pattern <= '0;
      for (int i = 0; i < pMATCH_RULES; i++) cnt[i] <= '0;
    end else if (eval) begin
      O_matching_pattern <= hit;
      O_trig <= I_trig_toggle ? O_trig ^ |hit : |hit;
      for (int i = 0; i < pMATCH_RULES; i++)
        if (hit[i] && cnt[i] != 8'hFF) cnt[i] <= cnt[i] + 8'd1;
    end else if (!I_trig_toggle) begin
      O_trig <= 1'b0;
    end
endmodule

// File: tb/tb_trace_tpiu_matcher.sv
// tb_trace_tpiu_matcher: directed checks of sync, byte assembly, matching, trigger and saturation
module tb_trace_tpiu_matcher;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] trace_data = '0;
  logic [2:0] width = 3'd4;
  logic reset_sync = 1'b0;
  logic [7:0] enable = 8'h01;
  logic toggle = 1'b0;
  logic [63:0] pat [8];
  logic [63:0] msk [8];
  logic synced, trig;
  logic [63:0] buffer, blurb;
  logic [7:0] matching;
  logic [7:0] cnt [8];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  trace_tpiu_matcher dut (
    .trace_clk(clk), .reset_i(rst), .trace_data(trace_data), .I_trace_width(width),
    .I_trace_reset_sync(reset_sync), .I_pattern_enable(enable), .I_trig_toggle(toggle),
    .I_trace_pattern0(pat[0]), .I_trace_pattern1(pat[1]), .I_trace_pattern2(pat[2]), .I_trace_pattern3(pat[3]),
    .I_trace_pattern4(pat[4]), .I_trace_pattern5(pat[5]), .I_trace_pattern6(pat[6]), .I_trace_pattern7(pat[7]),
    .I_trace_mask0(msk[0]), .I_trace_mask1(msk[1]), .I_trace_mask2(msk[2]), .I_trace_mask3(msk[3]),
    .I_trace_mask4(msk[4]), .I_trace_mask5(msk[5]), .I_trace_mask6(msk[6]), .I_trace_mask7(msk[7]),
    .O_synchronized(synced), .O_matching_buffer(buffer), .O_last_blurb(blurb),
    .O_matching_pattern(matching),
    .O_trace_count0(cnt[0]), .O_trace_count1(cnt[1]), .O_trace_count2(cnt[2]), .O_trace_count3(cnt[3]),
    .O_trace_count4(cnt[4]), .O_trace_count5(cnt[5]), .O_trace_count6(cnt[6]), .O_trace_count7(cnt[7]),
    .O_trig(trig)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [3:0] d);
    trace_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic sync4();
    for (int i = 0; i < 7; i++) tick(4'hF);
    tick(4'h7);
  endtask

  task automatic send4(input logic [7:0] b);
    tick(b[3:0]);
    tick(b[7:4]);
  endtask

  task automatic resync(input logic [2:0] w);
    reset_sync = 1'b1;
    width = w;
    tick(4'h0);
    reset_sync = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      pat[i] = '0;
      msk[i] = '0;
    end
    pat[0] = 64'hA5;
    msk[0] = 64'hFF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sync", synced, 0);
    check("rst_buf", buffer, 0);
    check("rst_trig", trig, 0);
    check("rst_cnt0", cnt[0], 0);
    rst = 1'b0;
    // width 4 sync
    for (int i = 0; i < 7; i++) tick(4'hF);
    check("t1_presync", synced, 0);
    tick(4'h7);
    check("t1_sync", synced, 1);
    check("t1_blurb", blurb, 64'h7FFF_FFFF_0000_0000);
    check("t1_buf", buffer, 0);
    // pulse trigger on 0xA5
    tick(4'h5);
    tick(4'hA);
    check("t2_buf", buffer, 64'hA5);
    check("t2_match_pre", matching, 0);
    check("t2_trig_pre", trig, 0);
    tick(4'h0);
    check("t2_match", matching, 8'h01);
    check("t2_cnt0", cnt[0], 1);
    check("t2_trig", trig, 1);
    tick(4'h0);
    check("t2_trig_off", trig, 0);
    check("t2_match_hold", matching, 8'h01);
    // toggle trigger, three 0xA5 bytes
    toggle = 1'b1;
    resync(3'd4);
    check("t3_clr_cnt0", cnt[0], 0);
    check("t3_clr_sync", synced, 0);
    sync4();
    check("t3_sync", synced, 1);
    send4(8'hA5);
    tick(4'h5);
    check("t3_trig1", trig, 1);
    tick(4'hA);
    check("t3_trig1_hold", trig, 1);
    tick(4'h5);
    check("t3_trig2", trig, 0);
    tick(4'hA);
    tick(4'h0);
    check("t3_trig3", trig, 1);
    check("t3_cnt0", cnt[0], 3);
    // width 1 sync, 0x3C byte, zero-mask rule never hits
    toggle = 1'b0;
    enable = 8'h07;
    pat[2] = 64'h3C;
    msk[2] = 64'hFF;
    resync(3'd1);
    for (int i = 0; i < 31; i++) tick(4'h1);
    check("t4_presync", synced, 0);
    tick(4'h0);
    check("t4_sync", synced, 1);
    check("t4_blurb", blurb[63:32], 32'h7FFF_FFFF);
    b = 8'h3C;
    for (int i = 0; i < 8; i++) tick({3'b000, b[i]});
    check("t4_buf", buffer, 64'h3C);
    tick(4'h0);
    check("t4_match", matching, 8'h04);
    check("t4_cnt1", cnt[1], 0);
    check("t4_cnt2", cnt[2], 1);
    check("t4_trig", trig, 1);
    // saturation at 255
    resync(3'd4);
    sync4();
    for (int i = 0; i < 300; i++) send4(8'hA5);
    tick(4'h0);
    check("t5_cnt0", cnt[0], 255);
    check("t5_cnt2", cnt[2], 0);
    check("t5_match", matching, 8'h01);
    // mid-byte resync
    reset_sync = 1'b1;
    tick(4'h5);
    reset_sync = 1'b0;
    check("t6_sync", synced, 0);
    check("t6_buf", buffer, 0);
    check("t6_cnt0", cnt[0], 0);
    check("t6_match", matching, 0);
    check("t6_blurb", blurb[63:32], 32'h7FFF_FFFF);
    send4(8'h5A);
    send4(8'h5A);
    check("t6_nopush", buffer, 0);
    check("t6_still_unsync", synced, 0);
    sync4();
    send4(8'hA5);
    check("t6_buf_after", buffer, 64'hA5);
    tick(4'h0);
    check("t6_cnt0_after", cnt[0], 1);
    // asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    check("async_buf", buffer, 0);
    check("async_sync", synced, 0);
    check("async_blurb", blurb, 0);
    check("async_cnt0", cnt[0], 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
